// File: rtl/bsg_mem_2r1w_sync_read_stage.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mem_2r1w_sync_read_stage
//  Purpose  : Read-side front end for a 2-read/1-write synchronous RAM with
//             one-cycle read latency. Each read port gets a valid/ready
//             request interface and a valid/yumi response interface. RAM
//             data is captured while the consumer stalls, so no response is
//             ever lost. With read_write_same_addr_p=0, a read that hits a
//             same-cycle write to the same address skips the RAM and returns
//             the forwarded write data instead.
//  Ports    : clk_i, reset_i (active-low, async)
//             w_v_i/w_addr_i/w_data_i      snooped RAM write port
//             rN_v_i/rN_addr_i/rN_ready_o  read request  (N = 0, 1)
//             rN_v_o/rN_data_o/rN_yumi_i   read response (N = 0, 1)
//             ram_rN_v_o/ram_rN_addr_o     RAM read enable/address
//             ram_rN_data_i                RAM read data (one cycle later)
//  Revision : 1.0  initial release
// ============================================================================
module bsg_mem_2r1w_sync_read_stage #(
    parameter int width_p                = -1,
    parameter int els_p                  = -1,
    parameter int read_write_same_addr_p = 0,
    parameter int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,

    input  logic                     r0_v_i,
    input  logic [addr_width_lp-1:0] r0_addr_i,
    output logic                     r0_ready_o,
    output logic                     r0_v_o,
    output logic [width_p-1:0]       r0_data_o,
    input  logic                     r0_yumi_i,

    input  logic                     r1_v_i,
    input  logic [addr_width_lp-1:0] r1_addr_i,
    output logic                     r1_ready_o,
    output logic                     r1_v_o,
    output logic [width_p-1:0]       r1_data_o,
    input  logic                     r1_yumi_i,

    output logic                     ram_r0_v_o,
    output logic [addr_width_lp-1:0] ram_r0_addr_o,
    input  logic [width_p-1:0]       ram_r0_data_i,

    output logic                     ram_r1_v_o,
    output logic [addr_width_lp-1:0] ram_r1_addr_o,
    input  logic [width_p-1:0]       ram_r1_data_i
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_pend  = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    // Per-port views so both ports share one generated implementation.
    logic [1:0]                    w_rv;
    logic [1:0]                    w_yumi;
    logic [1:0]                    w_ready;
    logic [1:0]                    w_v_o;
    logic [1:0]                    w_ram_v;
    logic [1:0][addr_width_lp-1:0] w_raddr;
    logic [1:0][width_p-1:0]       w_ram_data;
    logic [1:0][width_p-1:0]       w_data_o;

    assign w_rv       = {r1_v_i, r0_v_i};
    assign w_yumi     = {r1_yumi_i, r0_yumi_i};
    assign w_raddr    = {r1_addr_i, r0_addr_i};
    assign w_ram_data = {ram_r1_data_i, ram_r0_data_i};

    assign r0_ready_o    = w_ready[0];
    assign r1_ready_o    = w_ready[1];
    assign r0_v_o        = w_v_o[0];
    assign r1_v_o        = w_v_o[1];
    assign r0_data_o     = w_data_o[0];
    assign r1_data_o     = w_data_o[1];
    assign ram_r0_v_o    = w_ram_v[0];
    assign ram_r1_v_o    = w_ram_v[1];
    assign ram_r0_addr_o = r0_addr_i;
    assign ram_r1_addr_o = r1_addr_i;

    // Holds ready low while in reset and releases it at the first clock
    // edge after reset deassertion.
    logic r_live;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    for (genvar i = 0; i < 2; i++) begin : g_port
        logic [1:0]         r_state;
        logic [1:0]         w_state_nxt;
        logic               r_byp;
        logic [width_p-1:0] r_byp_data;
        logic [width_p-1:0] r_hold_data;
        logic               w_busy;
        logic               w_acc;
        logic               w_col;

        assign w_busy = (r_state == c_st_pend) || (r_state == c_st_hold);

        // A new request may enter whenever the response slot is empty or is
        // being drained this cycle.
        assign w_ready[i] = r_live & ((r_state == c_st_empty) | (w_busy & w_yumi[i]));
        assign w_acc      = w_rv[i] & w_ready[i];
        assign w_col      = w_acc & w_v_i & (w_addr_i == w_raddr[i])
                          & (read_write_same_addr_p == 0);
        assign w_ram_v[i] = w_acc & ~w_col;

        // State register
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) r_state <= c_st_empty;
            else          r_state <= w_state_nxt;
        end

        // Next-state logic
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_st_empty: if (w_acc) w_state_nxt = c_st_pend;
                c_st_pend,
                c_st_hold: begin
                    if (w_yumi[i]) w_state_nxt = w_acc ? c_st_pend : c_st_empty;
                    else           w_state_nxt = c_st_hold;
                end
                default:           w_state_nxt = c_st_empty;
            endcase
        end

        // Output logic: in PEND the RAM (or forwarded write) data is live;
        // everywhere else the captured copy is presented.
        always_comb begin
            w_v_o[i]    = w_busy;
            w_data_o[i] = r_hold_data;
            if (r_state == c_st_pend)
                w_data_o[i] = r_byp ? r_byp_data : w_ram_data[i];
        end

        // Bypass capture on accept, and capture of the live response the
        // first cycle it is stalled (the RAM output is only valid once).
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                r_byp       <= 1'b0;
                r_byp_data  <= '0;
                r_hold_data <= '0;
            end else begin
                if (w_acc) begin
                    r_byp <= w_col;
                    if (w_col) r_byp_data <= w_data_i;
                end
                if ((r_state == c_st_pend) && !w_yumi[i])
                    r_hold_data <= w_data_o[i];
            end
        end

`ifndef SYNTHESIS
        a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_i)
            w_yumi[i] |-> w_v_o[i])
            else $error("read port %0d: yumi asserted without a valid response", i);

        a_addr_in_range : assert property (@(posedge clk_i) disable iff (!reset_i)
            w_acc |-> (32'(w_raddr[i]) < 32'(els_p)))
            else $error("read port %0d: address out of range on accept", i);
`endif
    end

endmodule
`default_nettype wire
